// File: rtl/pulse_shaper_pkg.sv
// Shared definitions for pulse_shaper: FSM state encoding and count sanitizing.
package pulse_shaper_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  localparam int unsigned SAN_W = 32;

  // A zero width/repeat count means "one"; callers cast to their own width (<= SAN_W).
  function automatic logic [SAN_W-1:0] sanitize(input logic [SAN_W-1:0] v);
    return (v == '0) ? SAN_W'(1) : v;
  endfunction

endpackage

// File: rtl/pulse_shaper_counter.sv
// phase_counter: loadable down-counter that holds at zero and flags it.
module phase_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/pulse_shaper.sv
// Expands a trigger tick into delay + N programmable high/low pulses.
// Optional retrigger-while-busy behaviour: define PULSE_SHAPER_RETRIGGER_EN.
module pulse_shaper
  import pulse_shaper_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned REP_W       = 8,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [REP_W-1:0] repeat_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done_tick
);

  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] high_lat, low_lat;
  logic [REP_W-1:0] rep;
  logic [CNT_W-1:0] high_in_c, low_in_c;
  logic [REP_W-1:0] rep_in_c;
  logic             start_c;
  logic             cnt_zero_c;
  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             rep_dec_c;
  logic             rep_zero_c;
  logic             pulse_nxt_c;
  logic             busy_nxt_c;
  logic             done_nxt_c;

  assign high_in_c  = CNT_W'(sanitize(SAN_W'(high_cycles)));
  assign low_in_c   = CNT_W'(sanitize(SAN_W'(low_cycles)));
  assign rep_in_c   = REP_W'(sanitize(SAN_W'(repeat_count)));
  assign rep_zero_c = (rep == '0);

`ifdef PULSE_SHAPER_RETRIGGER_EN
  assign start_c = trigger & ~abort;
`else
  assign start_c = trigger & ~abort & (state == IDLE);
`endif

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .zero_c   (cnt_zero_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort of a running sequence beats any trigger
  always_comb begin
    next_state = state;
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end else if (start_c) begin
      next_state = (delay_cycles == '0) ? HIGH : DELAY;
    end else if (cnt_zero_c) begin
      case (state)
        DELAY:   next_state = HIGH;
        HIGH:    next_state = rep_zero_c ? IDLE : LOW;
        LOW:     next_state = HIGH;
        default: next_state = state;
      endcase
    end
  end

  // Counter control and next values of the registered outputs
  always_comb begin
    cnt_load_c  = start_c || (next_state != state);
    cnt_val_c   = '0;
    rep_dec_c   = (state == HIGH) && (next_state == LOW);
    done_nxt_c  = (state == HIGH) && (next_state == IDLE) && !abort;
    busy_nxt_c  = (next_state != IDLE);
    pulse_nxt_c = (next_state == HIGH) ? ACTIVE_HIGH : ~ACTIVE_HIGH;
    if (start_c) begin
      cnt_val_c = (delay_cycles == '0) ? (high_in_c - CNT_W'(1))
                                       : (delay_cycles - CNT_W'(1));
    end else if (next_state == HIGH) begin
      cnt_val_c = high_lat - CNT_W'(1);
    end else if (next_state == LOW) begin
      cnt_val_c = low_lat - CNT_W'(1);
    end
  end

  // Configuration capture, repeat counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_lat  <= '0;
      low_lat   <= '0;
      rep       <= '0;
      pulse_out <= ~ACTIVE_HIGH;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      if (start_c) begin
        high_lat <= high_in_c;
        low_lat  <= low_in_c;
        rep      <= rep_in_c - REP_W'(1);
      end else if (rep_dec_c) begin
        rep <= rep - REP_W'(1);
      end
      pulse_out <= pulse_nxt_c;
      busy      <= busy_nxt_c;
      done_tick <= done_nxt_c;
    end
  end

endmodule

// File: tb/tb_pulse_shaper.sv
// Self-checking bench for pulse_shaper against a timeline-arithmetic reference model.
module tb_pulse_shaper;

`ifdef PULSE_SHAPER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] delay_cycles = '0;
  logic [15:0] high_cycles = '0;
  logic [15:0] low_cycles = '0;
  logic [7:0]  repeat_count = '0;
  logic        pulse_p, busy_p, done_p;
  logic        pulse_n, busy_n, done_n;

  int checks = 0;
  int passed = 0;

  // Reference model: sequence described as offset k from the accepting edge E0
  bit m_active = 0;
  int m_k = 0, m_d = 0, m_h = 1, m_l = 1, m_r = 1;
  bit exp_p = 0, exp_b = 0, exp_dn = 0;

  always #5 clk = ~clk;

  pulse_shaper #(.CNT_W(16), .REP_W(8), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort),
    .delay_cycles(delay_cycles), .high_cycles(high_cycles),
    .low_cycles(low_cycles), .repeat_count(repeat_count),
    .pulse_out(pulse_p), .busy(busy_p), .done_tick(done_p)
  );

  pulse_shaper #(.CNT_W(16), .REP_W(8), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort),
    .delay_cycles(delay_cycles), .high_cycles(high_cycles),
    .low_cycles(low_cycles), .repeat_count(repeat_count),
    .pulse_out(pulse_n), .busy(busy_n), .done_tick(done_n)
  );

  function automatic int seq_len();
    return m_d + m_r * m_h + (m_r - 1) * m_l;
  endfunction

  function automatic bit in_high(int k);
    int j;
    if (k < m_d) return 1'b0;
    j = k - m_d;
    return ((j % (m_h + m_l)) < m_h) && ((j / (m_h + m_l)) < m_r);
  endfunction

  task automatic model_edge();
    exp_dn = 1'b0;
    if (m_active && abort) begin
      m_active = 0;
    end else if (trigger && !abort && (!m_active || RETRIG)) begin
      m_d = int'(delay_cycles);
      m_h = (high_cycles == 0) ? 1 : int'(high_cycles);
      m_l = (low_cycles == 0) ? 1 : int'(low_cycles);
      m_r = (repeat_count == 0) ? 1 : int'(repeat_count);
      m_k = 0;
      m_active = 1;
    end else if (m_active) begin
      m_k++;
      if (m_k == seq_len()) begin
        m_active = 0;
        exp_dn = 1'b1;
      end
    end
    exp_p = m_active && in_high(m_k);
    exp_b = m_active;
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
  endtask

  task automatic check_all(input string tag);
    check1({tag, ".pulse"}, pulse_p, exp_p);
    check1({tag, ".busy"}, busy_p, exp_b);
    check1({tag, ".done"}, done_p, exp_dn);
    check1({tag, ".pulse_inv"}, pulse_n, ~exp_p);
    check1({tag, ".busy_inv"}, busy_n, exp_b);
    check1({tag, ".done_inv"}, done_n, exp_dn);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic setcfg(input int d, input int h, input int l, input int r);
    delay_cycles = 16'(d);
    high_cycles  = 16'(h);
    low_cycles   = 16'(l);
    repeat_count = 8'(r);
  endtask

  task automatic fire(input string tag, input int tail);
    trigger = 1'b1;
    step(tag);
    trigger = 1'b0;
    setcfg(7, 7, 7, 7);
    for (int i = 0; i < tail; i++) step(tag);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step("idle");

    setcfg(2, 3, 1, 2);
    fire("d2h3l1r2", 12);

    setcfg(0, 0, 0, 0);
    fire("zeros", 4);

    setcfg(0, 10, 0, 1);
    fire("abort", 3);
    abort = 1'b1;
    step("abort_edge");
    abort = 1'b0;
    for (int i = 0; i < 10; i++) step("abort_after");

    setcfg(0, 0, 0, 0);
    trigger = 1'b1;
    abort = 1'b1;
    step("abort_idle");
    trigger = 1'b0;
    abort = 1'b0;
    step("abort_idle");

    setcfg(0, 5, 0, 1);
    fire("retrig", 1);
    setcfg(0, 5, 0, 1);
    trigger = 1'b1;
    step("retrig_e2");
    trigger = 1'b0;
    for (int i = 0; i < 8; i++) step("retrig_after");

    setcfg(0, 1, 0, 1);
    fire("back2back", 0);
    trigger = 1'b1;
    step("back2back_done");
    trigger = 1'b0;
    for (int i = 0; i < 3; i++) step("back2back");

    setcfg(0, 10, 0, 1);
    fire("rst_mid", 3);
    #2;
    rst = 1'b1;
    #1;
    m_active = 0;
    exp_p = 1'b0;
    exp_b = 1'b0;
    exp_dn = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    setcfg(1, 2, 3, 2);
    fire("after_rst", 10);

    setcfg(1, 2, 0, 1);
    fire("inv_d1h2", 5);

    setcfg(300, 2, 0, 1);
    fire("long_delay", 303);

    for (int n = 0; n < 3000; n++) begin
      setcfg($urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3), $urandom_range(0, 3));
      trigger = ($urandom_range(0, 5) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      step("random");
    end
    trigger = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 40; i++) step("drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_shaper.md
Name: pulse_shaper

Overview:
- Inverse of the tick path: expands a single-cycle trigger tick into a timed level waveform for driving sensor chip control pins (reset, transfer, shutter strobes).
- Sequence: programmable delay, then a burst of N high pulses, each with programmable high and low widths.
- Sits in the chip driver, downstream of the controller's tick sources and upstream of the pad outputs.

Parameters:
- CNT_W, 16, width of the delay, high and low cycle counts.
- REP_W, 8, width of the repeat count.
- ACTIVE_HIGH, 1, 1 = pulse_out idles low and asserts high; 0 = output is inverted at the port only.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- trigger  input  1  single-cycle start tick.
- abort  input  1  synchronous cancel of any running sequence.
- delay_cycles  input  CNT_W  low cycles between trigger and the first high phase.
- high_cycles  input  CNT_W  length of each high phase.
- low_cycles  input  CNT_W  gap between consecutive high phases.
- repeat_count  input  REP_W  number of high phases per trigger.
- pulse_out  output  1  shaped waveform, registered.
- busy  output  1  sequence in progress.
- done_tick  output  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Reset: state IDLE, all counters 0. pulse_out inactive (0 internally), busy 0, done_tick 0. Reset asserted mid-sequence aborts immediately and never produces done_tick.
- FSM states: IDLE, DELAY, HIGH, LOW.
- Configuration capture: all config inputs are latched at edge E0, the first edge at which trigger=1 is sampled in IDLE. Later changes to the inputs do not affect the running sequence.
- Zero handling: high_cycles=0, low_cycles=0 and repeat_count=0 are each treated as 1. delay_cycles=0 is a true zero delay.
- Transitions:
  - IDLE→DELAY at E0 if D>0.
  - IDLE→HIGH at E0 if D=0.
  - DELAY→HIGH after D cycles.
  - HIGH→LOW after H cycles if pulses remain.
  - HIGH→IDLE after H cycles on the last pulse.
  - LOW→HIGH after L cycles.
- Timing: pulse_out rises at edge E0+D. Each high phase lasts exactly H cycles; each gap lasts exactly L cycles. There is no trailing LOW phase after the last pulse.
- Completion: busy=1 from E0 until the edge where the last high phase ends. At that same edge pulse_out falls, busy falls and done_tick is high for exactly one cycle.
- Trigger while busy is ignored, unless the optional feature is compiled in. A trigger in the done_tick cycle is accepted, since the FSM is already IDLE.
- abort: while busy, the next edge forces IDLE, pulse_out inactive, busy 0, no done_tick. In IDLE, abort has no effect, and abort together with trigger means the trigger is ignored (abort wins).
- Counters: down-counters load count-1 on state entry and advance state at 0. There is no wrap-around. A max-value count (2^CNT_W-1) is exact.

Optional Feature:
- Macro: PULSE_SHAPER_RETRIGGER_EN.
- Defined: trigger while busy restarts the sequence. It re-latches configuration at that edge and re-enters DELAY/HIGH per the new D, exactly as from IDLE. pulse_out follows the new sequence from that edge, and no done_tick is issued for the cut-short sequence. abort still has priority over trigger.
- Undefined: trigger while busy is ignored; no retrigger logic is generated.

Decomposition:
- Shared package pulse_shaper_pkg holds:
  - state encoding localparams (IDLE=2'd0, DELAY=2'd1, HIGH=2'd2, LOW=2'd3);
  - the zero-to-one sanitize function for count inputs.
- Sub-module phase_counter (CNT_W-wide loadable down-counter with a zero flag), instantiated once. It is reloaded on each state entry.
- The repeat counter stays inline.

Test Plan:
- D=2, H=3, L=1, R=2, trigger at E0 -> pulse_out high during E2–E5 and E6–E9; busy high E0–E9; done_tick for 1 cycle at E9.
- D=0, H=0, R=0 -> treated as H=1, R=1: pulse_out high for 1 cycle from E0; done_tick at E1.
- Abort at E3 of sequence D=0, H=10, R=1 -> pulse_out and busy drop at E4; done_tick never asserted.
- Trigger again at E2 of a D=0, H=5, R=1 sequence, macro undefined -> ignored, done_tick at E5. With the macro defined -> restart, done_tick at E7 only.
- Async rst asserted mid-HIGH -> pulse_out, busy and done_tick go 0 immediately. After release, a new trigger runs normally.
- ACTIVE_HIGH=0, D=1, H=2, R=1 -> pulse_out idles 1 and is low during E1–E3.
